// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
// The optional return stack is enabled with the FETCH_RAS_EN macro.
package fetch_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 12;
  localparam int OPC_W_DEF   = 6;
  localparam int RAS_D_DEF   = 4;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack for call/return redirects (built only with FETCH_RAS_EN).
// Pop on empty yields 0, push on full overwrites the oldest entry; both set a sticky err.
module fetch_ras
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int RAS_D = RAS_D_DEF
) (
  input  logic            CK,
  input  logic            CLR,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_addr,
  output logic [PC_W-1:0] pop_addr,
  output logic            err
);

  localparam int SP_W  = (RAS_D > 1) ? $clog2(RAS_D) : 1;
  localparam int CNT_W = $clog2(RAS_D + 1);

  logic [PC_W-1:0]  stack [RAS_D];
  logic [SP_W-1:0]  sp_reg, sp_pop;
  logic [CNT_W-1:0] cnt_reg, cnt_pop;
  logic             empty, full_after_pop;

  assign empty = (cnt_reg == '0);

  // The pop is resolved first so a simultaneous push lands in the freed slot.
  always_comb begin
    sp_pop   = sp_reg;
    cnt_pop  = cnt_reg;
    pop_addr = '0;
    if (pop && !empty) begin
      sp_pop   = sp_reg - SP_W'(1);
      cnt_pop  = cnt_reg - CNT_W'(1);
      pop_addr = stack[sp_pop];
    end
  end

  assign full_after_pop = (cnt_pop == CNT_W'(RAS_D));

  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      sp_reg  <= '0;
      cnt_reg <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        sp_reg  <= sp_pop + SP_W'(1);
        cnt_reg <= full_after_pop ? cnt_pop : cnt_pop + CNT_W'(1);
      end else begin
        sp_reg  <= sp_pop;
        cnt_reg <= cnt_pop;
      end
      if ((pop && empty) || (push && full_after_pop)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (push) begin
      stack[sp_pop] <= push_addr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory handshake and an IR towards decode.
// Optional return stack for call/return redirects under the FETCH_RAS_EN macro.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF,
  parameter int RAS_D   = RAS_D_DEF
) (
  input  logic               CK,
  input  logic               CLR,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_oe,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [OPC_W-1:0]   ir_opc,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redir_valid,
  input  logic               redir_rel,
  input  logic [PC_W-1:0]    redir_off,
  input  logic               redir_call,
  input  logic               redir_ret,
  output logic               ras_err
);

  fetch_state_t       state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [PC_W-1:0]    ir_pc_reg, ir_pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic               ir_valid_reg, ir_valid_next;
  logic               discard_reg, discard_next;
  logic               armed_reg;
  logic               redir_take;
  logic [PC_W-1:0]    offset_target, target;

  assign redir_take    = redir_valid && ir_valid_reg;
  assign offset_target = redir_rel ? (ir_pc_reg + redir_off) : redir_off;

`ifdef FETCH_RAS_EN
  logic [PC_W-1:0] ras_addr;

  fetch_ras #(
    .PC_W  (PC_W),
    .RAS_D (RAS_D)
  ) u_ras (
    .CK        (CK),
    .CLR       (CLR),
    .push      (redir_take && redir_call),
    .pop       (redir_take && redir_ret),
    .push_addr (ir_pc_reg + PC_W'(1)),
    .pop_addr  (ras_addr),
    .err       (ras_err)
  );

  assign target = redir_ret ? ras_addr : offset_target;
`else
  logic unused_redir;
  assign unused_redir = &{1'b0, redir_call, redir_ret, RAS_D[0]};
  assign target       = offset_target;
  assign ras_err      = 1'b0;
`endif

  // armed_reg keeps the request strobe low while reset is held and for the release cycle.
  assign mem_oe   = (state_reg == ISSUE) && armed_reg;
  assign mem_addr = pc_reg;
  assign ir       = ir_reg;
  assign ir_opc   = ir_reg[OPC_W-1:0];
  assign ir_pc    = ir_pc_reg;
  assign ir_valid = ir_valid_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
    discard_next  = discard_reg;
    case (state_reg)
      ISSUE: begin
        if (armed_reg) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redir_take) begin
          // Unreachable while ir_valid is clear in WAIT; drops the in-flight word if it happens.
          pc_next       = target;
          ir_valid_next = 1'b0;
          discard_next  = !mem_valid;
          state_next    = mem_valid ? ISSUE : WAIT;
        end else if (mem_valid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = ISSUE;
          end else begin
            ir_next       = mem_data;
            ir_pc_next    = pc_reg;
            ir_valid_next = 1'b1;
            pc_next       = pc_reg + PC_W'(1);
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_take) begin
          pc_next       = target;
          ir_valid_next = 1'b0;
          state_next    = ISSUE;
        end else if (ir_valid_reg && ir_ready) begin
          ir_valid_next = 1'b0;
          state_next    = ISSUE;
        end
      end
      default: begin
        state_next = ISSUE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_reg    <= ISSUE;
      pc_reg       <= '0;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
      discard_reg  <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
      discard_reg  <= discard_next;
      armed_reg    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable memory model.
// Return-stack steps run only when FETCH_RAS_EN is defined.
module tb_fetch_unit;

  logic        CK = 1'b0;
  logic        CLR = 1'b0;
  logic [9:0]  mem_addr;
  logic        mem_oe;
  logic [11:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [11:0] ir;
  logic [5:0]  ir_opc;
  logic [9:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        redir_valid = 1'b0;
  logic        redir_rel = 1'b0;
  logic [9:0]  redir_off = '0;
  logic        redir_call = 1'b0;
  logic        redir_ret = 1'b0;
  logic        ras_err;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int oe_count = 0;
  int cnt = 0;
  logic       pend = 1'b0;
  logic [9:0] paddr = '0;

  always #5 CK = ~CK;

  fetch_unit dut (
    .CK          (CK),
    .CLR         (CLR),
    .mem_addr    (mem_addr),
    .mem_oe      (mem_oe),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .ir          (ir),
    .ir_opc      (ir_opc),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_rel   (redir_rel),
    .redir_off   (redir_off),
    .redir_call  (redir_call),
    .redir_ret   (redir_ret),
    .ras_err     (ras_err)
  );

  function automatic logic [11:0] word(input logic [9:0] a);
    return {2'b00, a} ^ 12'hA5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory: answers each request after lat cycles; flags responses outside WAIT and overlaps.
  always @(negedge CK) begin
    mem_valid = 1'b0;
    if (!CLR) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend      = 1'b0;
          mem_valid = 1'b1;
          mem_data  = word(paddr);
          chk("resp_in_wait", {30'b0, ir_valid, mem_oe}, 32'd0);
        end
      end
      if (mem_oe) begin
        oe_count++;
        chk("single_outstanding", {31'b0, pend}, 32'd0);
        pend  = 1'b1;
        paddr = mem_addr;
        cnt   = lat;
      end
    end
  end

  task automatic wait_irv(output int n);
    n = 0;
    do begin
      @(negedge CK);
      n++;
    end while (!ir_valid && n < 40);
    chk("ir_valid_seen", {31'b0, ir_valid}, 32'd1);
  endtask

  task automatic expect_fetch(input logic [9:0] a, output int n);
    wait_irv(n);
    $display("fetch ir_pc=0x%03h ir=0x%03h cycles=%0d", ir_pc, ir, n);
    chk("ir_pc", {22'b0, ir_pc}, {22'b0, a});
    chk("ir", {20'b0, ir}, {20'b0, word(a)});
    chk("ir_opc", {26'b0, ir_opc}, {20'b0, word(a) & 12'h03F});
  endtask

  task automatic redir(input logic rel, input logic [9:0] off, input logic call,
                       input logic ret, input logic [9:0] exp_addr, input string tag);
    redir_valid = 1'b1;
    redir_rel   = rel;
    redir_off   = off;
    redir_call  = call;
    redir_ret   = ret;
    @(negedge CK);
    redir_valid = 1'b0;
    redir_call  = 1'b0;
    redir_ret   = 1'b0;
    $display("redirect %s rel=%0d off=0x%03h -> mem_addr=0x%03h", tag, rel, off, mem_addr);
    chk({tag, "_oe"}, {31'b0, mem_oe}, 32'd1);
    chk(tag, {22'b0, mem_addr}, {22'b0, exp_addr});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_oe"}, {31'b0, mem_oe}, 32'd0);
    chk({tag, "_mem_addr"}, {22'b0, mem_addr}, 32'd0);
    chk({tag, "_ir"}, {20'b0, ir}, 32'd0);
    chk({tag, "_ir_pc"}, {22'b0, ir_pc}, 32'd0);
    chk({tag, "_ir_valid"}, {31'b0, ir_valid}, 32'd0);
    chk({tag, "_ras_err"}, {31'b0, ras_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int oe_before;

    repeat (2) @(negedge CK);
    check_reset_outputs("reset");
    #2 CLR = 1'b1;

    // Sequential fetch, latency 1 then 3, always ready.
    expect_fetch(10'h000, n);
    for (int k = 1; k < 8; k++) begin
      if (k == 5) lat = 3;
      oe_before = oe_count;
      expect_fetch(10'(k), n);
      chk("cycles_per_instr", n, (k < 5) ? 32'd3 : 32'd5);
      chk("oe_per_instr", oe_count - oe_before, 32'd1);
    end

    // Asynchronous reset while waiting on a latency-3 response.
    @(negedge CK);
    chk("issue_before_reset", {31'b0, mem_oe}, 32'd1);
    repeat ($urandom_range(1, 2)) @(negedge CK);
    #2 CLR = 1'b0;
    #1 check_reset_outputs("mid_wait_reset");
    @(negedge CK);
    lat      = 1;
    ir_ready = 1'b0;
    #2 CLR = 1'b1;
    n = 0;
    do begin
      @(negedge CK);
      n++;
    end while (!mem_oe && n < 10);
    chk("oe_after_reset", {31'b0, mem_oe}, 32'd1);
    chk("addr_after_reset", {22'b0, mem_addr}, 32'd0);
    expect_fetch(10'h000, n);

    // Decode stall holds ir and suppresses requests.
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      chk("stall_ir", {20'b0, ir}, {20'b0, word(10'h000)});
      chk("stall_ir_pc", {22'b0, ir_pc}, 32'd0);
      chk("stall_valid", {31'b0, ir_valid}, 32'd1);
      chk("stall_no_oe", {31'b0, mem_oe}, 32'd0);
    end
    ir_ready = 1'b1;
    @(negedge CK);
    chk("consume_oe", {31'b0, mem_oe}, 32'd1);
    chk("consume_addr", {22'b0, mem_addr}, 32'd1);
    ir_ready = 1'b0;
    expect_fetch(10'h001, n);

    // Absolute and PC-relative redirects, including wrap in both directions.
    redir(1'b0, 10'h010, 1'b0, 1'b0, 10'h010, "redir_abs_010");
    expect_fetch(10'h010, n);
    redir(1'b1, 10'h3F8, 1'b0, 1'b0, 10'h008, "redir_rel_m8");
    expect_fetch(10'h008, n);
    redir(1'b0, 10'h200, 1'b0, 1'b0, 10'h200, "redir_abs_200");
    expect_fetch(10'h200, n);
    redir(1'b1, 10'h1FF, 1'b0, 1'b0, 10'h3FF, "redir_rel_p1ff");
    expect_fetch(10'h3FF, n);
    redir(1'b1, 10'h003, 1'b0, 1'b0, 10'h002, "redir_rel_wrap");
    expect_fetch(10'h002, n);

    // PC wrap, redirect ignored without ir_valid, redirect beating a same-cycle consume.
    redir(1'b0, 10'h3FE, 1'b0, 1'b0, 10'h3FE, "redir_abs_3fe");
    expect_fetch(10'h3FE, n);
    ir_ready = 1'b1;
    @(negedge CK);
    chk("wrap_issue_addr", {22'b0, mem_addr}, 32'h3FF);
    @(negedge CK);
    chk("ignored_redir_no_ir", {31'b0, ir_valid}, 32'd0);
    redir_valid = 1'b1;
    redir_rel   = 1'b0;
    redir_off   = 10'h0AA;
    @(negedge CK);
    redir_valid = 1'b0;
    chk("ignored_redir_valid", {31'b0, ir_valid}, 32'd1);
    chk("ignored_redir_pc", {22'b0, ir_pc}, 32'h3FF);
    expect_fetch(10'h000, n);
    redir(1'b0, 10'h155, 1'b0, 1'b0, 10'h155, "redir_with_ready");
    ir_ready = 1'b0;
    expect_fetch(10'h155, n);

`ifdef FETCH_RAS_EN
    redir(1'b0, 10'h020, 1'b0, 1'b0, 10'h020, "redir_abs_020");
    expect_fetch(10'h020, n);
    redir(1'b0, 10'h100, 1'b1, 1'b0, 10'h100, "call_020");
    expect_fetch(10'h100, n);
    chk("ras_err_after_call", {31'b0, ras_err}, 32'd0);
    redir(1'b0, 10'h3AB, 1'b0, 1'b1, 10'h021, "ret_to_021");
    expect_fetch(10'h021, n);
    for (int i = 0; i < 5; i++) begin
      redir(1'b0, 10'h300, 1'b1, 1'b0, 10'h300, "call_fill");
      expect_fetch(10'h300, n);
      chk("ras_err_fill", {31'b0, ras_err}, (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      redir(1'b0, 10'h0FF, 1'b0, 1'b1, 10'h301, "ret_drain");
      expect_fetch(10'h301, n);
    end
    redir(1'b0, 10'h0FF, 1'b0, 1'b1, 10'h000, "ret_empty");
    expect_fetch(10'h000, n);
    chk("ras_err_sticky", {31'b0, ras_err}, 32'd1);
`else
    redir(1'b0, 10'h0F0, 1'b1, 1'b1, 10'h0F0, "callret_ignored");
    expect_fetch(10'h0F0, n);
    chk("ras_err_tied", {31'b0, ras_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
